sm_key_debouncer: RTL and testbench
===================================

// Module: sm_key_debouncer
// PURPOSE
//  Conditions raw board push-buttons (active-low, bouncing, asynchronous) before they reach
//  the clock divider and the CPU. Outputs per key: clean level, one-cycle press pulse and
//  one-cycle release pulse, all synchronous to clk. Sits between the KEYn pins and the
//  consumers of rst_n-gating / clock-enable / step signals on the board top.
// PARAMETERS
//  KEY_COUNT      2          number of independent keys
//  STABLE_CYCLES  1000000    cycles the input must hold a new level before it is accepted (10 ms @ 100 MHz); min 2
//  CNT_W          20         stability counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
// PORTS
//  clk          in   1          system clock (undivided board clock)
//  rst_n        in   1          asynchronous active-low reset
//  key_n        in   KEY_COUNT  raw button pins, 0 = pressed, asynchronous to clk
//  key_state    out  KEY_COUNT  debounced level, 1 = pressed
//  key_press    out  KEY_COUNT  1-cycle pulse on accepted press (and auto-repeat, see CONFIGURATION)
//  key_release  out  KEY_COUNT  1-cycle pulse on accepted release
// BEHAVIOUR
//  - Reset (async assert, sync to clk on deassert not required here): sync flops = 1 (released),
//    counters = 0, key_state = 0, key_press = 0, key_release = 0.
//  - Each key: 2-flop synchronizer on key_n; s = ~sync2 (1 = pressed).
//  - Per-key counter: cleared on any cycle where s == key_state; increments while s != key_state.
//  - Accept: on the edge where counter == STABLE_CYCLES-1 and s != key_state: key_state <= s,
//    counter <= 0, key_press <= s, key_release <= ~s. Pulses are high in the same cycle
//    key_state first shows the new level, low the following cycle.
//  - Latency pin -> key_state: 2 sync cycles + STABLE_CYCLES cycles, exactly.
//  - Glitch / bounce: any return of s to key_state before acceptance clears the counter; no output change.
//  - Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
//  - Keys fully independent; simultaneous acceptance on several keys yields simultaneous pulses.
//  - key_press and key_release of one key are never high in the same cycle.
//  - Reset mid-count or while pressed: everything returns to reset values; no release pulse is emitted.
// CONFIGURATION
//  Macro SM_KEY_DEBOUNCER_REPEAT_EN (adds parameters REPEAT_DELAY default 50000000,
//  REPEAT_PERIOD default 10000000, and a per-key repeat counter):
//  - Defined: while key_state == 1, repeat counter runs from the accept cycle; key_press pulses
//    again REPEAT_DELAY cycles after the accept pulse, then every REPEAT_PERIOD cycles.
//    Release or reset clears the repeat counter; no repeat pulse on/after the release cycle.
//  - Not defined: key_press pulses only on acceptance; repeat logic and parameters absent.
// STRUCTURE
//  - Package sm_key_pkg: default timing constants (STABLE_10MS_100MHZ, REPEAT_DELAY_DEF,
//    REPEAT_PERIOD_DEF) and the CNT_W derivation function.
//  - Sub-module sm_debounce_cell: one key (synchronizer, counter, accept logic, optional repeat);
//    top generate-instantiates KEY_COUNT cells. No shared state between cells.
// TESTING  (bench uses STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset: rst_n=0 with key_n=2'b00 -> all outputs 0; rst_n=1 -> key_state[1:0] 2'b11 exactly 6 cycles later,
//    key_press=2'b11 for 1 cycle.
//  2 Bounce: key_n[0] toggles 1-0-1-0 every 2 cycles, then holds 0 -> single key_press[0] 6 cycles after last edge.
//  3 Short glitch: key_n[0]=0 for 3 cycles -> no change in key_state/key_press/key_release.
//  4 Release: held key, key_n[0]=1 held -> key_release[0] 1 cycle, key_state[0]=0 after 6 cycles.
//  5 Reset mid-count: press, assert rst_n at count 2 -> outputs 0, no pulses; after release of rst_n, count restarts.
//  6 REPEAT_EN: hold key 30 cycles -> key_press at accept, accept+10, +13, +16, ...; none after release.

Source files
------------

// File: rtl/sm_key_debouncer_pkg.sv
// Shared timing defaults and counter-width helper for the key debouncer slice.
// Optional auto-repeat is enabled by defining SM_KEY_DEBOUNCER_REPEAT_EN.
package sm_key_pkg;

  localparam int STABLE_10MS_100MHZ = 32'd1000000;
  localparam int REPEAT_DELAY_DEF   = 32'd50000000;
  localparam int REPEAT_PERIOD_DEF  = 32'd10000000;

  // Smallest width w with 2**w >= cycles, never below 1.
  function automatic int calc_cnt_w(input int cycles);
    int w;
    w = 32'd1;
    while ((64'd1 << w) < 64'(cycles)) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sm_key_debouncer_if.sv
// Key pin / debounced-event bundle between the board pins and the debouncer.
interface sm_key_debouncer_if #(
  parameter int KEY_COUNT = 2
);

  logic [KEY_COUNT-1:0] key_n;
  logic [KEY_COUNT-1:0] key_state;
  logic [KEY_COUNT-1:0] key_press;
  logic [KEY_COUNT-1:0] key_release;

  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release
  );

endinterface

// File: rtl/sm_key_debouncer_cell.sv
// One-key debounce cell: 2-flop synchronizer, stability counter, accept logic and,
// when SM_KEY_DEBOUNCER_REPEAT_EN is defined, a key_press auto-repeat timer.
module sm_debounce_cell
  import sm_key_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_10MS_100MHZ,
  parameter int CNT_W         = calc_cnt_w(STABLE_CYCLES)
`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic key_state_o,
  output logic key_press_o,
  output logic key_release_o
);

  logic             sync1_q, sync2_q;
  logic             s_s;
  logic             accept_s;
  logic             rep_fire_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign s_s = ~sync2_q;

  // Stability counter and accept decision; a mismatch must persist STABLE_CYCLES edges.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    accept_s  = 1'b0;
    release_d = 1'b0;
    if (s_s == state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
      accept_s  = 1'b1;
      state_d   = s_s;
      cnt_d     = {CNT_W{1'b0}};
      release_d = ~s_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Press pulse merges the accept event with any auto-repeat event.
  always_comb begin
    press_d = (accept_s & s_s) | rep_fire_s;
  end

`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = calc_cnt_w(REP_MAX);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;

  // Repeat timer: first interval REPEAT_DELAY, later REPEAT_PERIOD; silent on any accept cycle.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire_s  = 1'b0;
    if (accept_s || !state_q) begin
      rep_cnt_d   = {REP_W{1'b0}};
      rep_first_d = 1'b1;
    end else if ((rep_first_q && (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))) ||
                 (!rep_first_q && (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)))) begin
      rep_fire_s  = 1'b1;
      rep_cnt_d   = {REP_W{1'b0}};
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + REP_W'(1);
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= {REP_W{1'b0}};
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  // Synchronizer, counter and registered outputs; sync flops idle at "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= {CNT_W{1'b0}};
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state_o   = state_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: rtl/sm_key_debouncer.sv
// Debouncer top: one independent sm_debounce_cell per key behind the key bus interface.
// Define SM_KEY_DEBOUNCER_REPEAT_EN to add key_press auto-repeat.
module sm_key_debouncer
  import sm_key_pkg::*;
#(
  parameter int KEY_COUNT     = 2,
  parameter int STABLE_CYCLES = STABLE_10MS_100MHZ,
  parameter int CNT_W         = calc_cnt_w(STABLE_CYCLES)
`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  sm_key_debouncer_if.slave   bus
);

  logic [KEY_COUNT-1:0] state_s;
  logic [KEY_COUNT-1:0] press_s;
  logic [KEY_COUNT-1:0] release_s;

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    sm_debounce_cell #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_n_i       (bus.key_n[k]),
      .key_state_o   (state_s[k]),
      .key_press_o   (press_s[k]),
      .key_release_o (release_s[k])
    );
  end

  assign bus.key_state   = state_s;
  assign bus.key_press   = press_s;
  assign bus.key_release = release_s;

endmodule

// File: tb/tb_sm_key_debouncer.sv
// Directed bench for sm_key_debouncer with STABLE_CYCLES=4 (REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Iteration c samples outputs at a falling edge, then drives pins for the next rising edges.
module tb_sm_key_debouncer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sm_key_debouncer_if #(.KEY_COUNT(2)) bus ();

  sm_key_debouncer #(
    .KEY_COUNT     (2),
    .STABLE_CYCLES (4),
    .CNT_W         (2)
`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
    ,
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [1:0] exp_state, exp_press, exp_release;
    rst_n = 1'b0;
    bus.key_n = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.key_state, bus.key_press, bus.key_release} !== 6'b000000) begin
        errors++;
        $display("FAIL reset_hold c=%0d got state=%b press=%b release=%b want all 0",
                 c, bus.key_state, bus.key_press, bus.key_release);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      exp_state   = (c >= 6 && c < 13) ? 2'b11 : 2'b00;
      exp_press   = (c == 6) ? 2'b11 : 2'b00;
      exp_release = (c == 13) ? 2'b11 : 2'b00;
      checks++;
      if (bus.key_state !== exp_state) begin
        errors++;
        $display("FAIL reset_state c=%0d got %b want %b", c, bus.key_state, exp_state);
      end
      checks++;
      if (bus.key_press !== exp_press) begin
        errors++;
        $display("FAIL reset_press c=%0d got %b want %b", c, bus.key_press, exp_press);
      end
      checks++;
      if (bus.key_release !== exp_release) begin
        errors++;
        $display("FAIL reset_release c=%0d got %b want %b", c, bus.key_release, exp_release);
      end
      if (c == 7) bus.key_n = 2'b11;
    end
  endtask

  task automatic test_bounce();
    logic kn;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.key_press[0] !== ((c == 14) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bounce_press c=%0d got %b want %b", c, bus.key_press[0], (c == 14));
      end
      checks++;
      if (bus.key_state[0] !== ((c >= 14) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bounce_state c=%0d got %b want %b", c, bus.key_state[0], (c >= 14));
      end
      checks++;
      if (bus.key_release !== 2'b00) begin
        errors++;
        $display("FAIL bounce_release c=%0d got %b want 00", c, bus.key_release);
      end
      kn = ((c >= 2 && c < 4) || (c >= 6 && c < 8)) ? 1'b1 : 1'b0;
      bus.key_n[0] = kn;
    end
  endtask

  task automatic test_release();
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) bus.key_n[0] = 1'b1;
      checks++;
      if (bus.key_release[0] !== ((c == 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL release_pulse c=%0d got %b want %b", c, bus.key_release[0], (c == 6));
      end
      checks++;
      if (bus.key_state[0] !== ((c < 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL release_state c=%0d got %b want %b", c, bus.key_state[0], (c < 6));
      end
      if (c >= 6) begin
        checks++;
        if (bus.key_press !== 2'b00) begin
          errors++;
          $display("FAIL release_nopress c=%0d got %b want 00", c, bus.key_press);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.key_state, bus.key_press, bus.key_release} !== 6'b000000) begin
        errors++;
        $display("FAIL glitch c=%0d got state=%b press=%b release=%b want all 0",
                 c, bus.key_state, bus.key_press, bus.key_release);
      end
      bus.key_n[0] = (c < 3) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    bus.key_n = 2'b01;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.key_state !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre got %b want 10", bus.key_state);
    end
    bus.key_n = 2'b00;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.key_state !== 2'b10) begin
      errors++;
      $display("FAIL midrst_count got %b want 10", bus.key_state);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.key_state, bus.key_press, bus.key_release} !== 6'b000000) begin
        errors++;
        $display("FAIL midrst_hold c=%0d got state=%b press=%b release=%b want all 0",
                 c, bus.key_state, bus.key_press, bus.key_release);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      checks++;
      if (bus.key_state !== ((c >= 6 && c < 14) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL midrst_state c=%0d got %b", c, bus.key_state);
      end
      checks++;
      if (bus.key_press !== ((c == 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL midrst_press c=%0d got %b", c, bus.key_press);
      end
      checks++;
      if (bus.key_release !== ((c == 14) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL midrst_release c=%0d got %b", c, bus.key_release);
      end
      if (c == 8) bus.key_n = 2'b11;
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
  task automatic test_repeat();
    logic exp_p;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      if (c == 0) bus.key_n[0] = 1'b0;
      if (c == 30) bus.key_n[0] = 1'b1;
      exp_p = ((c == 6) || (c >= 16 && c < 36 && ((c - 16) % 3) == 0)) ? 1'b1 : 1'b0;
      checks++;
      if (bus.key_press[0] !== exp_p) begin
        errors++;
        $display("FAIL repeat_press c=%0d got %b want %b", c, bus.key_press[0], exp_p);
      end
      checks++;
      if (bus.key_release[0] !== ((c == 36) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL repeat_release c=%0d got %b want %b", c, bus.key_release[0], (c == 36));
      end
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.key_n = 2'b11;
    test_reset();
    test_bounce();
    test_release();
    test_glitch();
    test_reset_mid();
`ifdef SM_KEY_DEBOUNCER_REPEAT_EN
    test_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
